lfsr10_checker: RTL and testbench

LFSR10_CHECKER -- requirements
Module: lfsr10_checker

---
 rtl/lfsr10_checker.sv | 160 ++++++++++++++++
 tb/tb_lfsr10_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr10_checker.sv
// ----------------------------------------------------------------------------
// lfsr10_checker
//   Tracks a serial stream produced by a 10-bit XNOR-tap LFSR
//   (b[k+10] = b[k] XNOR b[k+3]). It predicts each valid bit from the last ten
//   received bits, acquires lock after SYNC_GOOD consecutive correct
//   predictions, and counts mispredictions while locked. Lock is dropped after
//   LOSS_THRESH consecutive mispredictions.
//
//   Ports
//     CLOCK_50   in   clock, rising edge
//     reset      in   synchronous active-low reset
//     in_bit     in   received serial bit
//     in_valid   in   qualifies in_bit
//     clr_count  in   synchronous clear of err_count (beats an increment)
//     locked     out  FSM is in LOCKED
//     stuck      out  history is all ones (XNOR lock-up pattern)
//     err_pulse  out  one-cycle pulse per misprediction counted while locked
//     err_count  out  saturating count of locked mispredictions
//
//   state    | meaning
//   SEARCH   | filling the history with the first 10 valid bits
//   ACQUIRE  | counting consecutive correct predictions toward lock
//   LOCKED   | tracking; mispredictions counted, consecutive run watched
// ----------------------------------------------------------------------------
module lfsr10_checker #(
    parameter int SYNC_GOOD   = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             clr_count,
    output logic             locked,
    output logic             stuck,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int GW = $clog2(SYNC_GOOD + 1);
    localparam int CW = $clog2(LOSS_THRESH + 1);

    logic [1:0]       state_q, state_d;
    logic [9:0]       hist_q, hist_d;
    logic [3:0]       fill_q, fill_d;
    logic [GW-1:0]    good_q, good_d;
    logic [CW-1:0]    consec_q, consec_d;
    logic             locked_q, locked_d;
    logic             stuck_q, stuck_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic predict;
    logic miss;

    // Prediction always uses the history before this bit is shifted in.
    assign predict = ~(hist_q[0] ^ hist_q[3]);
    assign miss    = in_bit ^ predict;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        good_d      = good_q;
        consec_d    = consec_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;

        if (in_valid) begin
            // The received bit, not the prediction, goes into the history so
            // a single corrupted bit cannot propagate indefinitely.
            hist_d = {in_bit, hist_q[9:1]};
            case (state_q)
                ST_SEARCH: begin
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd9) begin
                        state_d = ST_ACQUIRE;
                        good_d  = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (miss) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(SYNC_GOOD - 1)) begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (miss) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + ERR_W'(1);
                        end
                        if (consec_q == CW'(LOSS_THRESH - 1)) begin
                            // History is kept; only the counters restart.
                            state_d  = ST_SEARCH;
                            fill_d   = '0;
                            good_d   = '0;
                            consec_d = '0;
                        end else begin
                            consec_d = consec_q + CW'(1);
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    fill_d  = '0;
                    good_d  = '0;
                end
            endcase
        end

        if (clr_count) begin
            err_count_d = '0;
        end

        locked_d = (state_d == ST_LOCKED);
        stuck_d  = &hist_d;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= ST_SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            consec_q    <= '0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            consec_q    <= consec_d;
            locked_q    <= locked_d;
            stuck_q     <= stuck_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign stuck     = stuck_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr10_checker.sv
module tb_lfsr10_checker;

    localparam int EW = 3;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b0;
    logic          in_bit = 1'b0;
    logic          in_valid = 1'b0;
    logic          clr_count = 1'b0;
    logic          locked;
    logic          stuck;
    logic          err_pulse;
    logic [EW-1:0] err_count;

    lfsr10_checker #(
        .SYNC_GOOD   (16),
        .LOSS_THRESH (4),
        .ERR_W       (EW)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .clr_count (clr_count),
        .locked    (locked),
        .stuck     (stuck),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic          lk;
        logic          st;
        logic          pl;
        logic [EW-1:0] cnt;
    } obs_t;

    obs_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;

    // reference model state
    int         m_state = 0;   // 0 search, 1 acquire, 2 locked
    logic [9:0] m_hist = '0;
    int         m_fill = 0;
    int         m_good = 0;
    int         m_cons = 0;
    int         m_cnt = 0;

    // generator for the clean stream
    logic [9:0] gen = '0;

    task automatic model(input logic v, input logic b, input logic c, input logic r);
        obs_t e;
        logic pl;
        logic p;
        pl = 1'b0;
        if (!r) begin
            m_state = 0; m_hist = '0; m_fill = 0; m_good = 0; m_cons = 0; m_cnt = 0;
        end else begin
            if (v) begin
                p = ~(m_hist[0] ^ m_hist[3]);
                if (m_state == 0) begin
                    m_fill++;
                    if (m_fill == 10) begin m_state = 1; m_good = 0; end
                end else if (m_state == 1) begin
                    if (b != p) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == 16) m_state = 2;
                    end
                end else begin
                    if (b != p) begin
                        pl = 1'b1;
                        if (m_cnt < (1 << EW) - 1) m_cnt++;
                        m_cons++;
                        if (m_cons == 4) begin
                            m_state = 0; m_fill = 0; m_good = 0; m_cons = 0;
                        end
                    end else m_cons = 0;
                end
                m_hist = {b, m_hist[9:1]};
            end
            if (c) m_cnt = 0;
        end
        e.lk  = (m_state == 2);
        e.st  = (m_hist == 10'h3FF);
        e.pl  = pl;
        e.cnt = EW'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic step(input logic v, input logic b, input logic c, input logic r);
        obs_t o;
        obs_t e;
        in_valid = v; in_bit = b; clr_count = c; reset = r;
        model(v, b, c, r);
        @(posedge CLOCK_50);
        #1;
        o = {locked, stuck, err_pulse, err_count};
        if (err_pulse) pulses++;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%b expected=entry", o);
        end else begin
            e = sb_q.pop_front();
            assert (o === e) else begin
                failures++;
                $error("FAIL scoreboard observed=%b expected=%b (lk,st,pl,cnt)", o, e);
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one valid generator bit (optionally inverted) or one idle cycle
    task automatic send_gen(input logic v, input logic inv, input logic c);
        if (v) begin
            step(1'b1, gen[0] ^ inv, c, 1'b1);
            gen = {~(gen[0] ^ gen[3]), gen[9:1]};
        end else begin
            step(1'b0, 1'($urandom_range(0, 1)), c, 1'b1);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        gen = '0;
    endtask

    initial begin
        int vcount;
        do_reset();
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_count", int'(err_count), 0);

        // clean stream, lock after 26th valid bit
        for (int i = 1; i <= 30; i++) begin
            send_gen(1'b1, 1'b0, 1'b0);
            if (i == 25) check_val("pre_lock_25", int'(locked), 0);
            if (i == 26) check_val("lock_at_26", int'(locked), 1);
        end
        check_val("clean_count", int'(err_count), 0);

        // single inverted bit -> three pulses, lock held
        pulses = 0;
        for (int i = 0; i < 3; i++) send_gen(1'b1, 1'b0, 1'b0);
        send_gen(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) send_gen(1'b1, 1'b0, 1'b0);
        check_val("inv_pulses", pulses, 3);
        check_val("inv_count", int'(err_count), 3);
        check_val("inv_locked", int'(locked), 1);

        // plain clear
        send_gen(1'b1, 1'b0, 1'b1);
        check_val("clr_count", int'(err_count), 0);

        // clear coincident with a locked misprediction
        send_gen(1'b1, 1'b1, 1'b1);
        check_val("clr_pulse", int'(err_pulse), 1);
        check_val("clr_wins", int'(err_count), 0);
        for (int i = 0; i < 12; i++) send_gen(1'b1, 1'b0, 1'b0);
        check_val("after_clr_count", int'(err_count), 2);

        // saturation at 7 with ERR_W=3
        for (int k = 0; k < 3; k++) begin
            send_gen(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 12; i++) send_gen(1'b1, 1'b0, 1'b0);
        end
        check_val("saturate", int'(err_count), 7);
        check_val("sat_locked", int'(locked), 1);

        // relock from reset, then constant zero stream until lock is lost
        do_reset();
        for (int i = 0; i < 26; i++) send_gen(1'b1, 1'b0, 1'b0);
        check_val("relock", int'(locked), 1);
        pulses = 0;
        for (int i = 0; i < 40 && locked; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("zero_lock_lost", int'(locked), 0);
        check_val("zero_pulses_vs_count", pulses, int'(err_count));
        check_val("zero_min_pulses", int'(pulses >= 4), 1);

        // gapped stream: lock after 26 valid bits regardless of gaps
        do_reset();
        vcount = 0;
        for (int i = 0; i < 60; i++) begin
            send_gen(i[0] == 1'b0, 1'b0, 1'b0);
            if (i[0] == 1'b0) begin
                vcount++;
                if (vcount == 25) check_val("gap_pre_lock", int'(locked), 0);
                if (vcount == 26) check_val("gap_lock_26", int'(locked), 1);
            end else begin
                check_val("gap_no_pulse", int'(err_pulse), 0);
            end
        end

        // reset mid-lock beats valid and clear
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_val("midrst_outputs", int'({locked, stuck, err_pulse, err_count}), 0);

        // all-ones stream: stuck but locks
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 26; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1);
            if (i == 9)  check_val("ones_stuck_9", int'(stuck), 0);
            if (i == 10) check_val("ones_stuck_10", int'(stuck), 1);
            if (i == 25) check_val("ones_pre_lock", int'(locked), 0);
        end
        check_val("ones_locked", int'(locked), 1);
        check_val("ones_count", int'(err_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
